// File: rtl/rtc_ext_loader_pkg.sv
// Shared constants, field layout and FSM state type for the EXT_RTC loader.
// Frame byte order, error codes and bit positions of the published 65-bit word.
package rtc_pkg;

  localparam int unsigned FRAME_BYTES = 7;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned RTC_W       = 65;

  localparam logic [IDX_W-1:0] IDX_SEC  = 3'd0;
  localparam logic [IDX_W-1:0] IDX_MIN  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_HOUR = 3'd2;
  localparam logic [IDX_W-1:0] IDX_DAY  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_MON  = 3'd4;
  localparam logic [IDX_W-1:0] IDX_YEAR = 3'd5;
  localparam logic [IDX_W-1:0] IDX_WDAY = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SHORT   = 2'd3;

  localparam int unsigned SEC_LSB    = 0;
  localparam int unsigned MIN_LSB    = 8;
  localparam int unsigned HOUR_LSB   = 16;
  localparam int unsigned DAY_LSB    = 24;
  localparam int unsigned MON_LSB    = 32;
  localparam int unsigned YEAR_LSB   = 40;
  localparam int unsigned WDAY_LSB   = 48;
  localparam int unsigned WDAY_W     = 4;
  localparam int unsigned TOGGLE_BIT = 64;

  // Lower 64 bits of EXT_RTC, MSB first.
  typedef struct packed {
    logic [11:0]       rsvd;
    logic [WDAY_W-1:0] wday;
    logic [7:0]        year;
    logic [7:0]        month;
    logic [7:0]        day;
    logic [7:0]        hour;
    logic [7:0]        min;
    logic [7:0]        sec;
  } rtc_time_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  function automatic logic is_bcd(input logic [7:0] d);
    return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_ext_loader_if.sv
// Host byte channel plus published EXT_RTC word and status pulses.
interface rtc_ext_loader_if;
  import rtc_pkg::*;

  logic             byte_valid;
  logic             frame_start;
  logic [7:0]       di_byte;
  logic [RTC_W-1:0] ext_rtc;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output byte_valid, frame_start, di_byte,
    input  ext_rtc, done, err, err_code
  );

  modport slave (
    input  byte_valid, frame_start, di_byte,
    output ext_rtc, done, err, err_code
  );

endinterface

// File: rtl/rtc_bcd_check.sv
// Per-byte range check of one BCD time field selected by its frame index.
module rtc_bcd_check
  import rtc_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       di,
  output logic             ok_c
);

  always_comb begin
    ok_c = 1'b0;
    case (idx)
      IDX_SEC, IDX_MIN: ok_c = is_bcd(di) && (di <= 8'h59);
      IDX_HOUR:         ok_c = is_bcd(di) && (di <= 8'h23);
      IDX_DAY:          ok_c = is_bcd(di) && (di >= 8'h01) && (di <= 8'h31);
      IDX_MON:          ok_c = is_bcd(di) && (di >= 8'h01) && (di <= 8'h12);
      IDX_YEAR:         ok_c = is_bcd(di);
      IDX_WDAY:         ok_c = (di[7:4] == 4'd0) && (di[3:0] <= 4'd6);
      default:          ok_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/rtc_ext_loader.sv
// Collects a 7-byte BCD time frame, range-checks it and publishes EXT_RTC,
// flipping bit 64 once per accepted frame so the S-RTC loads it exactly once.
module rtc_ext_loader
  import rtc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2147727,
  parameter logic [63:0] DEFAULT_RTC    = 64'h0006_0001_0100_0000
)(
  input  logic              CLK,
  input  logic              RST_N,
  rtc_ext_loader_if.slave   bus
);

  localparam int unsigned    CNT_W   = 32;
  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               bad, bad_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [7:0]         shadow [FRAME_BYTES];
  logic               shadow_we;
  logic [IDX_W-1:0]   shadow_idx;

  logic [RTC_W-1:0]   ext_rtc_q, ext_rtc_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic               byte_in;
  logic               start_in;
  logic [IDX_W-1:0]   chk_idx;
  logic               byte_ok_c;
  rtc_time_t          pub_c;

  assign byte_in  = bus.byte_valid;
  assign start_in = bus.byte_valid & bus.frame_start;

  // A frame-start byte is always checked as seconds, even when it restarts a frame.
  assign chk_idx = ((state == ST_COLLECT) && !bus.frame_start) ? idx : IDX_SEC;

  rtc_bcd_check u_chk (
    .idx  (chk_idx),
    .di   (bus.di_byte),
    .ok_c (byte_ok_c)
  );

  // Weekday high nibble is zero whenever the frame passes the check.
  always_comb begin
    pub_c       = '0;
    pub_c.sec   = shadow[IDX_SEC];
    pub_c.min   = shadow[IDX_MIN];
    pub_c.hour  = shadow[IDX_HOUR];
    pub_c.day   = shadow[IDX_DAY];
    pub_c.month = shadow[IDX_MON];
    pub_c.year  = shadow[IDX_YEAR];
    pub_c.wday  = shadow[IDX_WDAY][WDAY_W-1:0];
    pub_c.rsvd  = {8'h00, shadow[IDX_WDAY][7:WDAY_W]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    bad_d      = bad;
    cnt_d      = cnt;
    shadow_we  = 1'b0;
    shadow_idx = idx;
    ext_rtc_d  = ext_rtc_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;

    case (state)
      ST_IDLE: begin
        if (start_in) begin
          shadow_we  = 1'b1;
          shadow_idx = IDX_SEC;
          idx_d      = IDX_MIN;
          bad_d      = ~byte_ok_c;
          cnt_d      = '0;
          state_d    = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (start_in) begin
          err_d      = 1'b1;
          code_d     = ERR_SHORT;
          shadow_we  = 1'b1;
          shadow_idx = IDX_SEC;
          idx_d      = IDX_MIN;
          bad_d      = ~byte_ok_c;
          cnt_d      = '0;
        end else if (byte_in) begin
          // An arriving byte beats a simultaneous timeout expiry.
          shadow_we  = 1'b1;
          shadow_idx = idx;
          bad_d      = bad | ~byte_ok_c;
          cnt_d      = '0;
          if (idx == IDX_WDAY) begin
            idx_d   = '0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end else if (TO_EN && (cnt == TO_LAST)) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          idx_d   = '0;
          bad_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (TO_EN) begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (!bad) begin
          ext_rtc_d = {~ext_rtc_q[TOGGLE_BIT], 64'(pub_c)};
          done_d    = 1'b1;
        end else begin
          err_d  = 1'b1;
          code_d = ERR_RANGE;
        end
        bad_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx       <= '0;
      bad       <= 1'b0;
      cnt       <= '0;
      shadow    <= '{default: '0};
      ext_rtc_q <= {1'b0, DEFAULT_RTC};
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      idx       <= idx_d;
      bad       <= bad_d;
      cnt       <= cnt_d;
      if (shadow_we) shadow[shadow_idx] <= bus.di_byte;
      ext_rtc_q <= ext_rtc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign bus.ext_rtc  = ext_rtc_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;

endmodule

// File: tb/tb_rtc_ext_loader.sv
// Directed bench for rtc_ext_loader: table of whole frames plus hand-written
// short-frame, timeout, stray-byte and mid-frame reset sequences.
module tb_rtc_ext_loader;
  import rtc_pkg::*;

  localparam logic [63:0] DEF = 64'h0006_0001_0100_0000;
  localparam int unsigned NV  = 8;

  typedef struct packed {
    logic [0:6][7:0] b;
    logic            ok;
    logic [63:0]     word;
  } vec_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  int          checks   = 0;
  int          failures = 0;
  logic        tog      = 1'b0;
  logic [63:0] exp_word = DEF;
  vec_t        vecs [NV];

  rtc_ext_loader_if bus ();

  rtc_ext_loader #(
    .TIMEOUT_CYCLES (16),
    .DEFAULT_RTC    (DEF)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fs, input logic [7:0] d);
    @(negedge CLK);
    bus.byte_valid  = v;
    bus.frame_start = fs;
    bus.di_byte     = d;
  endtask

  task automatic send_frame(input logic [0:6][7:0] f);
    for (int i = 0; i < 7; i++) drive(1'b1, (i == 0), f[i]);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  // Call right after send_frame: result is visible one negedge later.
  task automatic check_result(input string name, input logic ok, input logic [63:0] word);
    @(negedge CLK);
    if (ok) begin
      tog      = ~tog;
      exp_word = word;
    end
    chk({name, "_done"}, 65'(bus.done), 65'(ok));
    chk({name, "_err"},  65'(bus.err),  65'(!ok));
    if (!ok) chk({name, "_code"}, 65'(bus.err_code), 65'(ERR_RANGE));
    chk({name, "_ext"}, bus.ext_rtc, {tog, exp_word});
    @(negedge CLK);
    chk({name, "_pulse"}, 65'({bus.done, bus.err}), 65'(0));
  endtask

  initial begin
    vecs[0] = '{b: {8'h45, 8'h30, 8'h23, 8'h31, 8'h12, 8'h99, 8'h06}, ok: 1'b1, word: 64'h0006_9912_3123_3045};
    vecs[1] = '{b: {8'h60, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00}, ok: 1'b0, word: 64'h0};
    vecs[2] = '{b: {8'h00, 8'h00, 8'h24, 8'h01, 8'h01, 8'h00, 8'h00}, ok: 1'b0, word: 64'h0};
    vecs[3] = '{b: {8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, ok: 1'b0, word: 64'h0};
    vecs[4] = '{b: {8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h07}, ok: 1'b0, word: 64'h0};
    vecs[5] = '{b: {8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00}, ok: 1'b1, word: 64'h0000_0001_0100_0000};
    vecs[6] = '{b: {8'h00, 8'h5A, 8'h00, 8'h32, 8'h01, 8'h00, 8'h00}, ok: 1'b0, word: 64'h0};
    vecs[7] = '{b: {8'h59, 8'h59, 8'h00, 8'h15, 8'h07, 8'h24, 8'h03}, ok: 1'b1, word: 64'h0003_2407_1500_5959};

    bus.byte_valid  = 1'b0;
    bus.frame_start = 1'b0;
    bus.di_byte     = 8'h00;
    repeat (3) @(negedge CLK);
    chk("reset_ext",  bus.ext_rtc, {1'b0, DEF});
    chk("reset_done", 65'(bus.done), 65'(0));
    chk("reset_err",  65'(bus.err), 65'(0));
    chk("reset_code", 65'(bus.err_code), 65'(ERR_NONE));
    RST_N = 1'b1;

    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].b);
      check_result($sformatf("vec%0d", i), vecs[i].ok, vecs[i].word);
    end

    // Stray byte in IDLE is ignored.
    drive(1'b1, 1'b0, 8'h45);
    drive(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge CLK);
    chk("stray_flags", 65'({bus.done, bus.err}), 65'(0));
    chk("stray_ext", bus.ext_rtc, {tog, exp_word});

    // Short frame: 4 bytes, then restart with a full good frame.
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b1, 8'h10);
    drive(1'b1, 1'b0, 8'h20);
    chk("short_err",  65'(bus.err), 65'(1));
    chk("short_code", 65'(bus.err_code), 65'(ERR_SHORT));
    chk("short_done", 65'(bus.done), 65'(0));
    drive(1'b1, 1'b0, 8'h08);
    drive(1'b1, 1'b0, 8'h05);
    drive(1'b1, 1'b0, 8'h06);
    drive(1'b1, 1'b0, 8'h23);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b0, 1'b0, 8'h00);
    check_result("restart", 1'b1, 64'h0001_2306_0508_2010);

    // Timeout: 3 bytes then 16 idle cycles.
    drive(1'b1, 1'b1, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    drive(1'b1, 1'b0, 8'h03);
    drive(1'b0, 1'b0, 8'h00);
    repeat (15) @(negedge CLK);
    chk("to_early", 65'(bus.err), 65'(0));
    @(negedge CLK);
    chk("to_err",  65'(bus.err), 65'(1));
    chk("to_code", 65'(bus.err_code), 65'(ERR_TIMEOUT));
    chk("to_ext",  bus.ext_rtc, {tog, exp_word});
    send_frame({8'h00, 8'h00, 8'h12, 8'h28, 8'h02, 8'h01, 8'h05});
    check_result("after_to", 1'b1, 64'h0005_0102_2812_0000);

    // Byte arriving on the expiry cycle wins over the timeout.
    drive(1'b1, 1'b1, 8'h30);
    drive(1'b0, 1'b0, 8'h00);
    repeat (14) @(negedge CLK);
    drive(1'b1, 1'b0, 8'h15);
    drive(1'b1, 1'b0, 8'h09);
    chk("edge_noerr", 65'(bus.err), 65'(0));
    drive(1'b1, 1'b0, 8'h10);
    drive(1'b1, 1'b0, 8'h11);
    drive(1'b1, 1'b0, 8'h05);
    drive(1'b1, 1'b0, 8'h02);
    drive(1'b0, 1'b0, 8'h00);
    check_result("edge_pub", 1'b1, 64'h0002_0511_1009_1530);

    // Reset after 5 bytes, then tail bytes without FRAME_START.
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b0, 8'h02);
    drive(1'b1, 1'b0, 8'h03);
    drive(1'b1, 1'b0, 8'h04);
    drive(1'b1, 1'b0, 8'h05);
    @(negedge CLK);
    bus.byte_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    tog      = 1'b0;
    exp_word = DEF;
    chk("rst_ext",  bus.ext_rtc, {tog, exp_word});
    chk("rst_flag", 65'({bus.done, bus.err}), 65'(0));
    chk("rst_code", 65'(bus.err_code), 65'(ERR_NONE));
    @(negedge CLK);
    RST_N = 1'b1;
    drive(1'b1, 1'b0, 8'h06);
    drive(1'b1, 1'b0, 8'h03);
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("tail_flags%0d", i), 65'({bus.done, bus.err}), 65'(0));
    end
    chk("tail_ext", bus.ext_rtc, {tog, exp_word});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
